pwm_ctrl_multi: RTL and testbench
=================================

Name: pwm_ctrl_multi

Overview:
- Parametrised successor to the four-channel PWM register bank.
- Holds NUM_CH PWM channels with byte-lane-writable configuration registers behind the same BRAM-style port (ena/wea/addr/din/dout).
- Adds per-channel enable, polarity and glitch-free shadowed period/duty updates, and generates the PWM waveforms itself.
- Adds a sticky period-wrap status register with a maskable interrupt. Sits between the processor BRAM-controller port and the pads/motor drivers.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- FREQ_W, 16, period register width in clock ticks (2..32).
- DUTY_W, 16, duty compare width (1..FREQ_W).
- ADDR_W, 13, byte address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  one clock; reset is asynchronous and active-high.
- ena  in  1  access enable.
- wea  in  4  byte-lane write enables; bit k covers din[8k+7:8k].
- addr  in  ADDR_W  byte address, word aligned.
- din  in  32  write data.
- dout  out  32  read data, combinational from addr.
- pwm_out  out  NUM_CH  registered PWM outputs.
- irq  out  1  registered interrupt.

Behaviour:
- Register map; full ADDR_W compare; unmapped or n>=NUM_CH reads 0, writes ignored:
  - CTRL 0x0000: [NUM_CH-1:0] ch_en; [8+NUM_CH-1:8] pol (1 = active-low). Reset 0.
  - STATUS 0x0004: [NUM_CH-1:0] wrap flags, sticky, write-1-to-clear. Reset 0.
  - IRQ_EN 0x0008: [NUM_CH-1:0] mask. Reset 0.
  - FREQ_n 0x0100+4n: [FREQ_W-1:0]. Reset 100.
  - DUTY_n 0x0200+4n: [DUTY_W-1:0]. Reset 0.
- Writes happen only when ena=1, per byte lane with wea[k]=1. Unimplemented bits are ignored and read 0. Takes effect next clock edge.
- dout is independent of ena and shows current programmed (not shadow) values.
- Shadow per channel: freq_act/duty_act.
  - Loaded from FREQ_n/DUTY_n every cycle while ch_en[n]=0.
  - While enabled, loaded only on the wrap cycle.
  - A write landing on the wrap edge is not seen until the following wrap.
- Counter cnt_n (FREQ_W bits):
  - ch_en=0: cnt=0.
  - ch_en=1, freq_act=0: cnt held 0, no wrap.
  - Otherwise cnt increments; when cnt==freq_act-1 next cnt=0 (wrap).
  - freq_act=1: wraps every cycle.
- Wrap event sets STATUS[n]. Set has priority over a same-cycle W1C.
- raw_n = ch_en[n] & (freq_act!=0) & (cnt_n < duty_act), with duty_act zero-extended to FREQ_W.
  - duty_act=0: raw always low.
  - duty_act>=freq_act: raw always high.
- pwm_out[n] <= raw_n ^ pol[n]. One cycle of latency from cnt. Disabled channel drives its inactive level (pol).
- Enable 0->1: the first enabled cycle has cnt=0 with shadows already loaded. pwm_out follows one cycle later.
- Disable 1->0: cnt returns to 0 next edge; output goes inactive the edge after. No partial-period completion.
- irq <= |(STATUS & IRQ_EN). Reset 0.
- Reset (async, any time) forces all registers, shadows and counters to reset values. pwm_out goes to 0 immediately. pol=0, so this is the inactive level.

Test Plan:
- Reset checks: read CTRL, STATUS, IRQ_EN, FREQ0..3, DUTY0..3 -> 0,0,0,100×4,0×4. Read 0x0300 -> 0. pwm_out=0, irq=0.
- Basic waveform: FREQ0=10, DUTY0=3, CTRL=0x1 -> pwm_out[0] repeats 3 high / 7 low from 1 cycle after enable; STATUS=0x1 after the 10th enabled cycle.
- Shadow update: while running (FREQ0=10, DUTY0=3), write DUTY0=6 at cnt=4 -> current period stays 3 high; next period 6 high / 4 low; no glitch.
- Byte lanes: wea=0001, din=0x000000AB to FREQ1 -> reads 0x000000AB. Then wea=0010, din=0x00001200 -> reads 0x000012AB. wea=0000 with ena=1 -> unchanged.
- Polarity / boundaries: CTRL=0x0202 (ch1 enabled, pol1=1), DUTY1=0 -> pwm_out[1] constantly 1. DUTY1=FREQ1 -> constantly 0 after next wrap. FREQ2=0 with ch2 enabled -> no wrap, STATUS[2]=0.
- Interrupt and mid-run reset: IRQ_EN=0x1, wrap sets STATUS[0] -> irq=1 next cycle. W1C 0x1 on a wrap cycle -> bit stays 1. Assert reset mid-period -> pwm_out=0 and irq=0 immediately; FREQ0 reads 100 afterwards.

Source files
------------

// File: rtl/pwm_ctrl_multi_if.sv
// BRAM-style register port shared by the processor controller and the PWM bank.
interface pwm_ctrl_multi_if #(
    parameter int unsigned ADDR_W = 13
);
    logic              ena;
    logic [3:0]        wea;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [31:0]       dout;

    modport master (output ena, wea, addr, din, input dout);
    modport slave  (input ena, wea, addr, din, output dout);
endinterface

// File: rtl/pwm_ctrl_multi.sv
// Multi-channel PWM generator with byte-lane-writable registers, per-channel
// enable/polarity, shadowed period/duty and a sticky wrap status with interrupt.
module pwm_ctrl_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned FREQ_W = 16,
    parameter int unsigned DUTY_W = 16,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clock,
    input  logic              reset,
    pwm_ctrl_multi_if.slave   bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(32'h0000);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'h0004);
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN = ADDR_W'(32'h0008);

    function automatic logic [ADDR_W-1:0] freq_addr(input int unsigned n);
        return ADDR_W'(32'h0100 + 4 * n);
    endfunction

    function automatic logic [ADDR_W-1:0] duty_addr(input int unsigned n);
        return ADDR_W'(32'h0200 + 4 * n);
    endfunction

    // Replace only the byte lanes selected by be; other lanes keep old.
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return (old & ~mask) | (data & mask);
    endfunction

    logic [NUM_CH-1:0] ch_en_q, ch_en_d, pol_q, pol_d;
    logic [NUM_CH-1:0] status_q, status_d, irq_en_q, irq_en_d, clr;
    logic [NUM_CH-1:0] wrap, raw, load;
    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [FREQ_W-1:0] freq_d [NUM_CH];
    logic [DUTY_W-1:0] duty_q [NUM_CH];
    logic [DUTY_W-1:0] duty_d [NUM_CH];
    logic [FREQ_W-1:0] freq_act_q [NUM_CH];
    logic [DUTY_W-1:0] duty_act_q [NUM_CH];
    logic [FREQ_W-1:0] cnt_q [NUM_CH];
    logic [FREQ_W-1:0] cnt_d [NUM_CH];
    logic [31:0]       ctrl_rd;

    assign ctrl_rd = 32'(ch_en_q) | (32'(pol_q) << 8);

    // Per-channel wrap detection, raw compare, shadow load and counter next state.
    always_comb begin
        wrap = '0;
        raw  = '0;
        load = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            wrap[n] = ch_en_q[n] && (freq_act_q[n] != '0) &&
                      (cnt_q[n] == freq_act_q[n] - FREQ_W'(1));
            raw[n]  = ch_en_q[n] && (freq_act_q[n] != '0) &&
                      (cnt_q[n] < FREQ_W'(duty_act_q[n]));
            // Shadows track the programmed values until the channel runs.
            load[n] = !ch_en_q[n] || wrap[n];
            if (!ch_en_q[n] || (freq_act_q[n] == '0) || wrap[n]) begin
                cnt_d[n] = '0;
            end else begin
                cnt_d[n] = cnt_q[n] + FREQ_W'(1);
            end
        end
    end

    // Register-bank write decode with byte-lane merging and W1C status.
    always_comb begin
        ch_en_d  = ch_en_q;
        pol_d    = pol_q;
        irq_en_d = irq_en_q;
        clr      = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            freq_d[n] = freq_q[n];
            duty_d[n] = duty_q[n];
        end
        if (bus.ena) begin
            if (bus.addr == ADDR_CTRL) begin
                ch_en_d = NUM_CH'(lane_merge(ctrl_rd, bus.din, bus.wea));
                pol_d   = NUM_CH'(lane_merge(ctrl_rd, bus.din, bus.wea) >> 8);
            end
            if (bus.addr == ADDR_STATUS) begin
                clr = NUM_CH'(lane_merge(32'h0, bus.din, bus.wea));
            end
            if (bus.addr == ADDR_IRQ_EN) begin
                irq_en_d = NUM_CH'(lane_merge(32'(irq_en_q), bus.din, bus.wea));
            end
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (bus.addr == freq_addr(n)) begin
                    freq_d[n] = FREQ_W'(lane_merge(32'(freq_q[n]), bus.din, bus.wea));
                end
                if (bus.addr == duty_addr(n)) begin
                    duty_d[n] = DUTY_W'(lane_merge(32'(duty_q[n]), bus.din, bus.wea));
                end
            end
        end
        // A wrap in the same cycle as a clear wins.
        status_d = (status_q & ~clr) | wrap;
    end

    // Read mux shows programmed values, independent of ena.
    always_comb begin
        bus.dout = '0;
        if (bus.addr == ADDR_CTRL)   bus.dout = ctrl_rd;
        if (bus.addr == ADDR_STATUS) bus.dout = 32'(status_q);
        if (bus.addr == ADDR_IRQ_EN) bus.dout = 32'(irq_en_q);
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (bus.addr == freq_addr(n)) bus.dout = 32'(freq_q[n]);
            if (bus.addr == duty_addr(n)) bus.dout = 32'(duty_q[n]);
        end
    end

    // Configuration and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ch_en_q  <= '0;
            pol_q    <= '0;
            status_q <= '0;
            irq_en_q <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                freq_q[n] <= FREQ_W'(100);
                duty_q[n] <= '0;
            end
        end else begin
            ch_en_q  <= ch_en_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                freq_q[n] <= freq_d[n];
                duty_q[n] <= duty_d[n];
            end
        end
    end

    // Shadow period/duty and period counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                freq_act_q[n] <= FREQ_W'(100);
                duty_act_q[n] <= '0;
                cnt_q[n]      <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (load[n]) begin
                    freq_act_q[n] <= freq_q[n];
                    duty_act_q[n] <= duty_q[n];
                end
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Registered pad outputs and interrupt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_out <= '0;
            irq     <= 1'b0;
        end else begin
            pwm_out <= raw ^ pol_q;
            irq     <= |(status_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_pwm_ctrl_multi.sv
// Directed and randomized bench for pwm_ctrl_multi against an arithmetic PWM model.
module tb_pwm_ctrl_multi;

    localparam logic [12:0] A_CTRL   = 13'h000;
    localparam logic [12:0] A_STATUS = 13'h004;
    localparam logic [12:0] A_IRQ_EN = 13'h008;
    localparam logic [12:0] A_FREQ0  = 13'h100;
    localparam logic [12:0] A_DUTY0  = 13'h200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pwm_out;
    logic       irq;
    int         n_assert = 0;
    int         n_fail = 0;

    pwm_ctrl_multi_if #(.ADDR_W(13)) bus ();

    pwm_ctrl_multi #(
        .NUM_CH(4),
        .FREQ_W(16),
        .DUTY_W(16),
        .ADDR_W(13)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .pwm_out(pwm_out),
        .irq    (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.ena  = 1'b1;
        bus.wea  = be;
        bus.addr = a;
        bus.din  = d;
        tick();
        bus.ena  = 1'b0;
        bus.wea  = 4'h0;
    endtask

    task automatic read_check(input string tag, input logic [12:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(tag, bus.dout, exp);
    endtask

    // Model: after the enabling edge, sample j reflects period position (j-1) mod F.
    function automatic logic model_pwm(input int j, input int f, input int d, input logic pol);
        return ((((j - 1) % f) < d) ? 1'b1 : 1'b0) ^ pol;
    endfunction

    initial begin
        int    ch;
        int    f;
        int    d;
        logic  pol;
        logic  e;

        bus.ena  = 1'b0;
        bus.wea  = 4'h0;
        bus.addr = '0;
        bus.din  = '0;

        // Reset state
        #3;
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0);
        read_check("rst_irqen", A_IRQ_EN, 32'h0);
        for (int n = 0; n < 4; n++) begin
            read_check($sformatf("rst_freq%0d", n), A_FREQ0 + 13'(4 * n), 32'd100);
            read_check($sformatf("rst_duty%0d", n), A_DUTY0 + 13'(4 * n), 32'd0);
        end
        read_check("rst_unmapped", 13'h300, 32'h0);
        read_check("rst_ch4", 13'h110, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Basic waveform: 3 high / 7 low
        write(A_FREQ0, 32'd10, 4'hF);
        write(A_DUTY0, 32'd3, 4'hF);
        write(A_CTRL, 32'h1, 4'hF);
        for (int j = 1; j <= 30; j++) begin
            tick();
            check($sformatf("basic_pwm%0d", j), 32'(pwm_out), 32'(model_pwm(j, 10, 3, 1'b0)));
            if (j == 9)  read_check("basic_status9", A_STATUS, 32'h0);
            if (j == 10) read_check("basic_status10", A_STATUS, 32'h1);
        end

        // Shadow update: mid-period write, and a write landing on the wrap edge
        write(A_CTRL, 32'h0, 4'hF);
        tick();
        write(A_STATUS, 32'hF, 4'hF);
        write(A_CTRL, 32'h1, 4'hF);
        for (int j = 1; j <= 40; j++) begin
            if (j == 5 || j == 20) begin
                bus.ena  = 1'b1;
                bus.wea  = 4'hF;
                bus.addr = A_DUTY0;
                bus.din  = (j == 5) ? 32'd6 : 32'd2;
            end
            tick();
            bus.ena = 1'b0;
            bus.wea = 4'h0;
            d = (j <= 10) ? 3 : (j <= 30) ? 6 : 2;
            check($sformatf("shadow_pwm%0d", j), 32'(pwm_out), 32'(model_pwm(j, 10, d, 1'b0)));
        end

        // Byte lanes
        write(A_CTRL, 32'h0, 4'hF);
        write(13'h104, 32'h0000_00AB, 4'b0001);
        read_check("lane0", 13'h104, 32'h0000_00AB);
        write(13'h104, 32'h0000_1200, 4'b0010);
        read_check("lane1", 13'h104, 32'h0000_12AB);
        write(13'h104, 32'hFFFF_FFFF, 4'b0000);
        read_check("lane_none", 13'h104, 32'h0000_12AB);
        write(13'h104, 32'hFF00_0000, 4'b1000);
        read_check("lane_unimpl", 13'h104, 32'h0000_12AB);

        // Polarity and duty boundaries on channel 1
        write(13'h104, 32'd8, 4'hF);
        write(13'h204, 32'd0, 4'hF);
        write(A_CTRL, 32'h0202, 4'hF);
        read_check("pol_ctrl", A_CTRL, 32'h0202);
        for (int j = 1; j <= 20; j++) begin
            tick();
            check($sformatf("pol_duty0_%0d", j), 32'(pwm_out), 32'h2);
        end
        write(13'h204, 32'd8, 4'hF);
        repeat (16) tick();
        for (int j = 1; j <= 16; j++) begin
            tick();
            check($sformatf("pol_dutyfull_%0d", j), 32'(pwm_out), 32'h0);
        end

        // Zero period: channel enabled but never wraps
        write(A_CTRL, 32'h0, 4'hF);
        write(13'h108, 32'd0, 4'hF);
        write(13'h208, 32'd5, 4'hF);
        write(A_CTRL, 32'h4, 4'hF);
        write(A_STATUS, 32'hF, 4'hF);
        repeat (20) tick();
        read_check("freq0_status", A_STATUS, 32'h0);
        check("freq0_pwm", 32'(pwm_out), 32'h0);

        // Interrupt, W1C vs wrap, mid-run reset
        write(A_CTRL, 32'h0, 4'hF);
        write(A_FREQ0, 32'd10, 4'hF);
        write(A_DUTY0, 32'd3, 4'hF);
        write(A_IRQ_EN, 32'h1, 4'hF);
        write(A_STATUS, 32'hF, 4'hF);
        tick();
        check("irq_idle", 32'(irq), 32'h0);
        write(A_CTRL, 32'h1, 4'hF);
        for (int j = 1; j <= 33; j++) begin
            if (j == 20 || j == 25) begin
                bus.ena  = 1'b1;
                bus.wea  = 4'hF;
                bus.addr = A_STATUS;
                bus.din  = 32'h1;
            end
            tick();
            bus.ena = 1'b0;
            bus.wea = 4'h0;
            if (j == 10) begin
                check("irq_before", 32'(irq), 32'h0);
                read_check("irq_status10", A_STATUS, 32'h1);
            end
            if (j == 11) check("irq_set", 32'(irq), 32'h1);
            if (j == 20) read_check("w1c_on_wrap", A_STATUS, 32'h1);
            if (j == 25) read_check("w1c_clear", A_STATUS, 32'h0);
            if (j == 26) check("irq_cleared", 32'(irq), 32'h0);
            if (j == 30) read_check("rewrap_status", A_STATUS, 32'h1);
            if (j == 31) check("irq_reset", 32'(irq), 32'h1);
        end
        check("pre_reset_pwm", 32'(pwm_out), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_pwm", 32'(pwm_out), 32'h0);
        check("midreset_irq", 32'(irq), 32'h0);
        read_check("midreset_freq0", A_FREQ0, 32'd100);
        read_check("midreset_status", A_STATUS, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Randomized single-channel waveforms
        for (int t = 0; t < 8; t++) begin
            ch  = int'($urandom_range(0, 3));
            f   = int'($urandom_range(1, 12));
            d   = int'($urandom_range(0, 14));
            pol = 1'($urandom_range(0, 1));
            write(A_CTRL, 32'h0, 4'hF);
            tick();
            write(A_STATUS, 32'hF, 4'hF);
            write(A_FREQ0 + 13'(4 * ch), 32'(f), 4'hF);
            write(A_DUTY0 + 13'(4 * ch), 32'(d), 4'hF);
            write(A_CTRL, (32'h1 << ch) | (32'(pol) << (8 + ch)), 4'hF);
            for (int j = 1; j <= 3 * f + 2; j++) begin
                tick();
                e = model_pwm(j, f, d, pol);
                check($sformatf("rand%0d_ch%0d_f%0d_d%0d_p%0d_j%0d", t, ch, f, d, pol, j),
                      32'(pwm_out), 32'(e) << ch);
                if (j == f - 1) read_check($sformatf("rand%0d_status_pre", t), A_STATUS, 32'h0);
                if (j == f) read_check($sformatf("rand%0d_status", t), A_STATUS, 32'h1 << ch);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
